// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Issuing side of the ALU port set in the 8-bit RISC datapath. It takes
//   instruction bytes from the instruction source, keeps a 4 x DW register
//   file, presents operands and opcode to the ALU for exactly one cycle, and
//   writes the ALU result and flags back.
//
// Ports
//   Iclk, Irst          clock (rising edge), asynchronous active-high reset
//   Iinstr, Ivalid      instruction / immediate byte and its valid
//   Oready              sequencer can take Iinstr this cycle
//   OIRa, OIRb, OOPALU  ALU operands and opcode (all zero outside EXEC)
//   IALUD, IFgz, IFgn   ALU result and flags
//   OFlagZ, OFlagN      registered ALU flags
//   Oretire             one-cycle pulse after an instruction completes
//   Idbg_sel, Odbg_data combinational register-file read port
//   Odbg_state          current FSM state (0 FETCH, 1 EXEC, 2 IMM)
//
// Handshake: a byte moves on every rising edge where Ivalid && Oready.
// The source holds Iinstr stable while Ivalid is high and Oready is low;
// Oready never depends on Ivalid. Oready is high in FETCH and IMM and low in
// EXEC and while Irst is asserted.
//
// Instruction byte: op=[7:5], rd=[3:2], rs=[1:0]; bit 4 is ignored.
//   0 NOP, 1 ADD, 2 SUB, 3 NAND, 4 SHL, 5 SHR, 6 MOV, 7 LDI (+ data byte)
module alu_sequencer #(
    parameter int            DW       = 8,
    parameter logic [DW-1:0] REG_INIT = '0
) (
    input  logic          Iclk,
    input  logic          Irst,
    input  logic [7:0]    Iinstr,
    input  logic          Ivalid,
    output logic          Oready,
    output logic [DW-1:0] OIRa,
    output logic [DW-1:0] OIRb,
    output logic [3:0]    OOPALU,
    input  logic [DW-1:0] IALUD,
    input  logic          IFgz,
    input  logic          IFgn,
    output logic          OFlagZ,
    output logic          OFlagN,
    output logic          Oretire,
    input  logic [1:0]    Idbg_sel,
    output logic [DW-1:0] Odbg_data,
    output logic [1:0]    Odbg_state
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_IMM   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0] rf [4];

    // Latched issue fields for the EXEC cycle (and rd for the IMM write).
    logic [DW-1:0] a_q, b_q;
    logic [2:0]    op_q;
    logic [1:0]    rd_q;

    logic [2:0] f_op;
    logic [1:0] f_rd, f_rs;
    logic       accept;

    // Next-state controls
    logic          we;
    logic [1:0]    waddr;
    logic [DW-1:0] wdata;
    logic          retire_d;
    logic          flag_we;
    logic          lat_alu;
    logic          lat_rd;

    assign f_op   = Iinstr[7:5];
    assign f_rd   = Iinstr[3:2];
    assign f_rs   = Iinstr[1:0];
    assign accept = Ivalid && Oready;

    // Ready is gated by reset directly so it is low the whole time Irst is high.
    assign Oready     = (state_q != S_EXEC) && !Irst;
    assign OIRa       = (state_q == S_EXEC) ? a_q : '0;
    assign OIRb       = (state_q == S_EXEC) ? b_q : '0;
    assign OOPALU     = (state_q == S_EXEC) ? {1'b0, op_q} : 4'd0;
    assign Odbg_data  = rf[Idbg_sel];
    assign Odbg_state = state_q;

    always_comb begin
        state_d  = state_q;
        we       = 1'b0;
        waddr    = rd_q;
        wdata    = IALUD;
        retire_d = 1'b0;
        flag_we  = 1'b0;
        lat_alu  = 1'b0;
        lat_rd   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (accept) begin
                    case (f_op)
                        3'd0: retire_d = 1'b1;
                        3'd6: begin
                            // MOV completes in the accept cycle; rf read happens before the write.
                            we       = 1'b1;
                            waddr    = f_rd;
                            wdata    = rf[f_rs];
                            retire_d = 1'b1;
                        end
                        3'd7: begin
                            lat_rd  = 1'b1;
                            state_d = S_IMM;
                        end
                        default: begin
                            lat_alu = 1'b1;
                            lat_rd  = 1'b1;
                            state_d = S_EXEC;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                we       = 1'b1;
                waddr    = rd_q;
                wdata    = IALUD;
                flag_we  = 1'b1;
                retire_d = 1'b1;
                state_d  = S_FETCH;
            end
            S_IMM: begin
                if (accept) begin
                    // Data byte is written verbatim, never decoded.
                    we       = 1'b1;
                    waddr    = rd_q;
                    wdata    = DW'(Iinstr);
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge Iclk or posedge Irst) begin
        if (Irst) begin
            state_q <= S_FETCH;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 3'd0;
            rd_q    <= 2'd0;
            OFlagZ  <= 1'b0;
            OFlagN  <= 1'b0;
            Oretire <= 1'b0;
            for (int i = 0; i < 4; i++) rf[i] <= REG_INIT;
        end else begin
            state_q <= state_d;
            Oretire <= retire_d;
            if (lat_alu) begin
                a_q  <= rf[f_rd];
                b_q  <= rf[f_rs];
                op_q <= f_op;
            end
            if (lat_rd) rd_q <= f_rd;
            if (flag_we) begin
                OFlagZ <= IFgz;
                OFlagN <= IFgn;
            end
            if (we) rf[waddr] <= wdata;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: behavioural ALU attached to the ALU ports,
// instruction-level reference model of registers/flags, table-driven ALU
// vectors, directed multi-cycle sequences and randomized instruction streams.
module tb_alu_sequencer;

  logic       Iclk;
  logic       Irst;
  logic [7:0] Iinstr;
  logic       Ivalid;
  logic       Oready;
  logic [7:0] OIRa, OIRb;
  logic [3:0] OOPALU;
  logic [7:0] IALUD;
  logic       IFgz, IFgn;
  logic       OFlagZ, OFlagN, Oretire;
  logic [1:0] Idbg_sel;
  logic [7:0] Odbg_data;
  logic [1:0] Odbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int retire_cnt = 0;

  // Reference model state
  logic [7:0] m_r [4];
  logic       m_z, m_n;
  logic [7:0] exp_q [$];

  alu_sequencer #(.DW(8), .REG_INIT(8'h00)) dut (
    .Iclk(Iclk), .Irst(Irst), .Iinstr(Iinstr), .Ivalid(Ivalid), .Oready(Oready),
    .OIRa(OIRa), .OIRb(OIRb), .OOPALU(OOPALU), .IALUD(IALUD), .IFgz(IFgz),
    .IFgn(IFgn), .OFlagZ(OFlagZ), .OFlagN(OFlagN), .Oretire(Oretire),
    .Idbg_sel(Idbg_sel), .Odbg_data(Odbg_data), .Odbg_state(Odbg_state)
  );

  // ---------------- clock / reset ----------------
  initial Iclk = 1'b0;
  always #5 Iclk = ~Iclk;
  always @(posedge Iclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ALU behaviour: {result, z, n} ----------------
  function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic z, n;
    r = 8'h00; z = 1'b0; n = 1'b0;
    case (op)
      4'd1: r = a + b;
      4'd2: r = a - b;
      4'd3: r = ~(a & b);
      4'd4: r = {a[6:0], 1'b0};
      4'd5: r = {1'b0, a[7:1]};
      default: r = 8'h00;
    endcase
    if (op >= 4'd1 && op <= 4'd3) begin
      z = (r == 8'h00);
      n = r[7];
    end else if (op == 4'd4) begin
      z = a[7];
    end else if (op == 4'd5) begin
      z = a[0];
    end
    return {r, z, n};
  endfunction

  assign {IALUD, IFgz, IFgn} = alu_fn(OOPALU, OIRa, OIRb);

  function automatic logic [7:0] enc(input int op, input int rd, input int rs);
    logic [7:0] v;
    v = {op[2:0], 1'b0, rd[1:0], rs[1:0]};
    return v;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reg(input string name, input int i, input logic [7:0] exp);
    Idbg_sel = i[1:0];
    #1;
    chk(name, Odbg_data, exp);
  endtask

  task automatic check_model();
    for (int i = 0; i < 4; i++) check_reg($sformatf("model_r%0d", i), i, m_r[i]);
    chk("model_flag_z", OFlagZ, m_z);
    chk("model_flag_n", OFlagN, m_n);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_z = 1'b0;
    m_n = 1'b0;
  endtask

  // Retire scoreboard: each pulse must match one expected completion.
  always @(negedge Iclk) begin
    if (Oretire) begin
      retire_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL retire_unexpected: got pulse expected none (t=%0t)", $time);
      end else begin
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (called just after a rising edge) ----------------
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    Iinstr = b;
    Ivalid = 1'b1;
    while (!Oready && n < 20) begin
      @(posedge Iclk); #1;
      n++;
    end
    if (!Oready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 20 cycles");
      Ivalid = 1'b0;
    end else begin
      @(posedge Iclk); #1;
      Ivalid = 1'b0;
    end
  endtask

  task automatic alu_issue_chk(input logic [7:0] ins);
    chk("exec_opcode", OOPALU, {1'b0, ins[7:5]});
    chk("exec_opa", OIRa, m_r[ins[3:2]]);
    chk("exec_opb", OIRb, m_r[ins[1:0]]);
    chk("exec_not_retired", Oretire, 1'b0);
    chk("exec_not_ready", Oready, 1'b0);
  endtask

  task automatic alu_complete(input logic [7:0] ins);
    logic [9:0] res;
    @(posedge Iclk); #1;
    res = alu_fn({1'b0, ins[7:5]}, m_r[ins[3:2]], m_r[ins[1:0]]);
    m_r[ins[3:2]] = res[9:2];
    m_z = res[1];
    m_n = res[0];
    exp_q.push_back(ins);
    chk("alu_retire", Oretire, 1'b1);
    chk("alu_port_idle", OOPALU, 4'd0);
  endtask

  task automatic do_instr(input logic [7:0] ins, input logic [7:0] imm);
    send(ins);
    case (ins[7:5])
      3'd0: begin
        exp_q.push_back(ins);
        chk("nop_retire", Oretire, 1'b1);
      end
      3'd6: begin
        m_r[ins[3:2]] = m_r[ins[1:0]];
        exp_q.push_back(ins);
        chk("mov_retire", Oretire, 1'b1);
        chk("mov_port_idle", OOPALU, 4'd0);
      end
      3'd7: begin
        chk("ldi_wait_ready", Oready, 1'b1);
        chk("ldi_no_early_retire", Oretire, 1'b0);
        chk("ldi_port_idle", OOPALU, 4'd0);
        send(imm);
        m_r[ins[3:2]] = imm;
        exp_q.push_back(ins);
        chk("ldi_retire", Oretire, 1'b1);
      end
      default: begin
        alu_issue_chk(ins);
        alu_complete(ins);
      end
    endcase
  endtask

  // ---------------- ALU vector table ----------------
  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       z;
    logic       n;
  } vec_t;

  vec_t vecs [10];

  // ---------------- main sequence ----------------
  initial begin
    int rc0;
    int t0;
    logic [7:0] ins;
    logic [7:0] imm;

    vecs[0] = '{3'd1, 8'h03, 8'h05, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{3'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{3'd2, 8'h40, 8'h40, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{3'd2, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b1};
    vecs[4] = '{3'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b1};
    vecs[5] = '{3'd3, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{3'd4, 8'h80, 8'h11, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{3'd4, 8'h41, 8'h22, 8'h82, 1'b0, 1'b0};
    vecs[8] = '{3'd5, 8'h01, 8'h33, 8'h00, 1'b1, 1'b0};
    vecs[9] = '{3'd5, 8'h82, 8'h44, 8'h41, 1'b0, 1'b0};

    Irst = 1'b1; Ivalid = 1'b0; Iinstr = 8'h00; Idbg_sel = 2'd0;
    model_reset();

    // Reset state
    @(posedge Iclk); @(posedge Iclk); #1;
    chk("rst_ready", Oready, 1'b0);
    chk("rst_opcode", OOPALU, 4'd0);
    chk("rst_opa", OIRa, 8'h00);
    chk("rst_retire", Oretire, 1'b0);
    chk("rst_flag_z", OFlagZ, 1'b0);
    chk("rst_flag_n", OFlagN, 1'b0);
    for (int i = 0; i < 4; i++) check_reg("rst_reg", i, 8'h00);
    Irst = 1'b0;
    @(posedge Iclk); #1;
    chk("post_rst_ready", Oready, 1'b1);

    // Scenario 1: LDI R1,3; LDI R2,5; ADD R1,R2 with three retire pulses
    rc0 = retire_cnt;
    do_instr(enc(7, 1, 0), 8'h03);
    do_instr(enc(7, 2, 0), 8'h05);
    send(enc(1, 1, 2));
    chk("s1_opa", OIRa, 8'h03);
    chk("s1_opb", OIRb, 8'h05);
    chk("s1_opcode", OOPALU, 4'd1);
    alu_complete(enc(1, 1, 2));
    @(negedge Iclk); #1;
    chk("s1_retire_count", retire_cnt - rc0, 3);
    check_reg("s1_r1", 1, 8'h08);
    chk("s1_z", OFlagZ, 1'b0);
    chk("s1_n", OFlagN, 1'b0);

    // Scenario 2: SUB R0,R0 then NAND R0,R0
    do_instr(enc(7, 0, 0), 8'h40);
    do_instr(enc(2, 0, 0), 8'h00);
    check_reg("s2_sub_r0", 0, 8'h00);
    chk("s2_sub_z", OFlagZ, 1'b1);
    chk("s2_sub_n", OFlagN, 1'b0);
    do_instr(enc(3, 0, 0), 8'h00);
    check_reg("s2_nand_r0", 0, 8'hFF);
    chk("s2_nand_z", OFlagZ, 1'b0);
    chk("s2_nand_n", OFlagN, 1'b1);

    // Scenario 3: SHL shifted-out bit into Z, then MOV keeps flags
    do_instr(enc(7, 3, 0), 8'h80);
    do_instr(enc(4, 3, 3), 8'h00);
    check_reg("s3_shl_r3", 3, 8'h00);
    chk("s3_shl_z", OFlagZ, 1'b1);
    chk("s3_shl_n", OFlagN, 1'b0);
    do_instr(enc(6, 0, 3), 8'h00);
    check_reg("s3_mov_r0", 0, 8'h00);
    chk("s3_mov_z", OFlagZ, 1'b1);
    chk("s3_mov_n", OFlagN, 1'b0);

    // Scenario 4: byte held during EXEC, back-to-back ADDs every 2 cycles
    do_instr(enc(7, 1, 0), 8'h10);
    do_instr(enc(7, 2, 0), 8'h03);
    ins = enc(1, 1, 2);
    send(ins);
    t0 = cyc;
    alu_issue_chk(ins);
    Iinstr = ins; Ivalid = 1'b1;
    #1;
    chk("s4_hold_not_ready", Oready, 1'b0);
    alu_complete(ins);
    chk("s4_ready_after_exec", Oready, 1'b1);
    send(ins);
    chk("s4_issue_interval", cyc - t0, 2);
    alu_issue_chk(ins);
    alu_complete(ins);
    check_reg("s4_r1", 1, 8'h16);

    // Table-driven ALU vectors
    for (int k = 0; k < 10; k++) begin
      do_instr(enc(7, 1, 0), vecs[k].a);
      do_instr(enc(7, 2, 0), vecs[k].b);
      do_instr(enc(vecs[k].op, 1, 2), 8'h00);
      check_reg($sformatf("vec%0d_r", k), 1, vecs[k].r);
      chk($sformatf("vec%0d_z", k), OFlagZ, vecs[k].z);
      chk($sformatf("vec%0d_n", k), OFlagN, vecs[k].n);
    end

    // Scenario 5a: reset in mid-EXEC drops the instruction
    do_instr(enc(7, 1, 0), 8'h80);
    do_instr(enc(7, 2, 0), 8'h01);
    do_instr(enc(1, 1, 2), 8'h00);
    chk("s5_pre_n", OFlagN, 1'b1);
    send(enc(1, 1, 2));
    Irst = 1'b1;
    #1;
    chk("s5_exec_rst_opcode", OOPALU, 4'd0);
    chk("s5_exec_rst_ready", Oready, 1'b0);
    chk("s5_exec_rst_n", OFlagN, 1'b0);
    chk("s5_exec_rst_retire", Oretire, 1'b0);
    check_reg("s5_exec_rst_r1", 1, 8'h00);
    @(posedge Iclk); #3;
    Irst = 1'b0;
    @(posedge Iclk); #1;
    model_reset();
    check_model();
    chk("s5_exec_rel_ready", Oready, 1'b1);

    // Scenario 5b: reset while waiting in IMM
    do_instr(enc(7, 3, 0), 8'h5A);
    send(enc(7, 3, 0));
    Irst = 1'b1;
    #1;
    chk("s5_imm_rst_ready", Oready, 1'b0);
    check_reg("s5_imm_rst_r3", 3, 8'h00);
    @(posedge Iclk); #3;
    Irst = 1'b0;
    @(posedge Iclk); #1;
    model_reset();
    do_instr(enc(7, 2, 0), 8'h7F);
    check_reg("s5_ldi_r2", 2, 8'h7F);
    check_model();

    // Scenario 6: wrap-around ADD, debug port shows pre-write value in EXEC
    do_instr(enc(7, 1, 0), 8'hFF);
    send(enc(1, 1, 1));
    alu_issue_chk(enc(1, 1, 1));
    check_reg("s6_dbg_prewrite", 1, 8'hFF);
    alu_complete(enc(1, 1, 1));
    check_reg("s6_r1", 1, 8'hFE);
    chk("s6_n", OFlagN, 1'b1);
    chk("s6_z", OFlagZ, 1'b0);

    // LDI data byte that looks like an opcode is not decoded
    do_instr(enc(7, 0, 0), 8'hE5);
    check_reg("ldi_raw_byte", 0, 8'hE5);
    chk("ldi_raw_ready", Oready, 1'b1);

    // Randomized instruction stream against the reference model
    for (int k = 0; k < 60; k++) begin
      ins = enc($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3));
      ins[4] = 1'($urandom_range(0, 1));
      imm = 8'($urandom_range(0, 255));
      do_instr(ins, imm);
      check_model();
      repeat ($urandom_range(0, 2)) begin
        @(posedge Iclk); #1;
      end
    end

    repeat (3) @(posedge Iclk);
    #1;
    chk("retire_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
